// File: rtl/soft_event_gen.sv
// soft_event_gen: software-commanded soft-event pulse bursts toward the event-trigger path.
// Each pulse is W cycles high then G cycles low; burst_count=0 runs until aborted.
module soft_event_gen #(
  parameter int PW_WIDTH  = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_enable,
  input  logic                 sw_req,
  input  logic                 sw_abort,
  input  logic [PW_WIDTH-1:0]  pulse_width,
  input  logic [CNT_WIDTH-1:0] gap_cycles,
  input  logic [CNT_WIDTH-1:0] burst_count,
  output logic                 evg_soft_event,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic                 req_overrun,
  output logic [CNT_WIDTH-1:0] pulses_sent
);
  // state | meaning
  // IDLE  | no burst in progress, line low
  // HIGH  | line high for the latched width
  // LOW   | line low for the latched gap
  typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [PW_WIDTH-1:0]  PW_ONE  = {{(PW_WIDTH-1){1'b0}}, 1'b1};

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] phase_cnt, phase_nxt;
  logic [PW_WIDTH-1:0]  width_lat, width_nxt, width_in;
  logic [CNT_WIDTH-1:0] gap_lat, gap_nxt, gap_in;
  logic [CNT_WIDTH-1:0] count_lat, count_nxt, sent_nxt;
  logic [CNT_WIDTH-1:0] width_in_ext, width_lat_ext;
  logic                 phase_end, last_pulse, start, abort_act;
  logic                 evg_nxt, busy_nxt, done_nxt, aborted_nxt, overrun_nxt;

  assign width_in   = (pulse_width == '0) ? PW_ONE : pulse_width;
  assign gap_in     = (gap_cycles == '0) ? CNT_ONE : gap_cycles;
  assign phase_end  = (phase_cnt == '0);
  assign last_pulse = (count_lat != '0) && (pulses_sent == count_lat);
  assign start      = (state == IDLE) && sw_req && !sw_abort;
  assign abort_act  = (state != IDLE) && sw_abort;

  always_comb begin
    width_in_ext                 = '0;
    width_in_ext[PW_WIDTH-1:0]   = width_in;
    width_lat_ext                = '0;
    width_lat_ext[PW_WIDTH-1:0]  = width_lat;
  end

  always_ff @(posedge clk) begin
    if (reset)           state <= IDLE;
    else if (clk_enable) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = HIGH;
      HIGH: begin
        if (sw_abort)       state_nxt = IDLE;
        else if (phase_end) state_nxt = LOW;
      end
      LOW: begin
        if (sw_abort)       state_nxt = IDLE;
        else if (phase_end) state_nxt = last_pulse ? IDLE : HIGH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // phase_cnt is a down-counter holding remaining cycles of the current phase minus one
  always_comb begin
    phase_nxt   = phase_cnt;
    width_nxt   = width_lat;
    gap_nxt     = gap_lat;
    count_nxt   = count_lat;
    sent_nxt    = pulses_sent;
    overrun_nxt = req_overrun;
    if (start) begin
      width_nxt   = width_in;
      gap_nxt     = gap_in;
      count_nxt   = burst_count;
      phase_nxt   = width_in_ext - CNT_ONE;
      sent_nxt    = CNT_ONE;
      overrun_nxt = 1'b0;
    end else if (state != IDLE && !sw_abort) begin
      if (sw_req) overrun_nxt = 1'b1;
      if (!phase_end) begin
        phase_nxt = phase_cnt - CNT_ONE;
      end else if (state == HIGH) begin
        phase_nxt = gap_lat - CNT_ONE;
      end else if (!last_pulse) begin
        phase_nxt = width_lat_ext - CNT_ONE;
        if (pulses_sent != CNT_MAX) sent_nxt = pulses_sent + CNT_ONE;
      end
    end
    evg_nxt     = (state_nxt == HIGH);
    busy_nxt    = (state_nxt != IDLE);
    done_nxt    = (state == LOW) && !sw_abort && phase_end && last_pulse;
    aborted_nxt = abort_act;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_cnt      <= '0;
      width_lat      <= '0;
      gap_lat        <= '0;
      count_lat      <= '0;
      pulses_sent    <= '0;
      evg_soft_event <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      aborted        <= 1'b0;
      req_overrun    <= 1'b0;
    end else begin
      // strobes must drop even while the block is frozen
      done    <= clk_enable & done_nxt;
      aborted <= clk_enable & aborted_nxt;
      if (clk_enable) begin
        phase_cnt      <= phase_nxt;
        width_lat      <= width_nxt;
        gap_lat        <= gap_nxt;
        count_lat      <= count_nxt;
        pulses_sent    <= sent_nxt;
        evg_soft_event <= evg_nxt;
        busy           <= busy_nxt;
        req_overrun    <= overrun_nxt;
      end
    end
  end

endmodule
